mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_byte_packer.sv | 37 +++
 rtl/mem_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the FSM states, the LSU access sizes and the UART-mapped store addresses.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IF_RD = 2'd1,
        LS_RD = 2'd2,
        LS_WR = 2'd3
    } state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [31:0] IO_ADDR_0 = 32'h0003_0000;
    localparam logic [31:0] IO_ADDR_1 = 32'h0003_0004;

    // Index of the final byte of an LSU access; the unused encoding 3 is treated as a word.
    function automatic logic [1:0] last_cnt(input logic [1:0] size);
        case (size)
            SIZE_BYTE: last_cnt = 2'd0;
            SIZE_HALF: last_cnt = 2'd1;
            default:   last_cnt = 2'd3;
        endcase
    endfunction

    function automatic logic is_io(input logic [31:0] addr);
        return (addr == IO_ADDR_0) || (addr == IO_ADDR_1);
    endfunction

endpackage

// File: rtl/mem_byte_packer.sv
// Assembles little-endian read data one byte per cycle into a 32-bit register.
// word_o already contains the byte being captured this cycle, so the final byte is usable immediately.
module mem_byte_packer
    import mem_ctrl_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clr_i,
    input  logic        en_i,
    input  logic [1:0]  cnt_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);

    logic [31:0] word_q;

    always_comb begin
        word_o = clr_i ? 32'd0 : word_q;
        if (en_i) begin
            case (cnt_i)
                2'd0:    word_o[7:0]   = byte_i;
                2'd1:    word_o[15:8]  = byte_i;
                2'd2:    word_o[23:16] = byte_i;
                default: word_o[31:24] = byte_i;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= 32'd0;
        end else if (clr_i || en_i) begin
            word_q <= word_o;
        end
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetches and LSU loads/stores onto a byte-wide RAM port.
// Every transaction returns to IDLE, which gives the mandatory idle cycle between accesses.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic [31:0] _ICache_addr,
    output logic        _mem_ready,
    output logic [15:0] _mem_inst_in,
    input  logic        _lsb_req,
    input  logic        _lsb_we,
    input  logic [31:0] _lsb_addr,
    input  logic [31:0] _lsb_wdata,
    input  logic [1:0]  _lsb_size,
    output logic        _lsb_done,
    output logic [31:0] _lsb_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        mem_ready_q;
    logic        lsb_done_q;
    logic        mem_wr_q;
    logic [31:0] mem_a_q;
    logic [7:0]  mem_dout_q;
    logic [15:0] inst_q;
    logic [31:0] lsb_rdata_q;

    logic [1:0]  last_d;
    logic [1:0]  cnt_inc_d;
    logic        wr_stall_d;
    logic [7:0]  wbyte_d;
    logic        pack_clr_d;
    logic        pack_en_d;
    logic [31:0] pack_word_d;

    assign last_d     = last_cnt(_lsb_size);
    assign cnt_inc_d  = cnt_q + 2'd1;
    assign wr_stall_d = is_io(_lsb_addr) && io_buffer_full;

    always_comb begin
        case (cnt_inc_d)
            2'd1:    wbyte_d = _lsb_wdata[15:8];
            2'd2:    wbyte_d = _lsb_wdata[23:16];
            2'd3:    wbyte_d = _lsb_wdata[31:24];
            default: wbyte_d = _lsb_wdata[7:0];
        endcase
    end

    // The packer is wiped on every IDLE edge so narrow loads come out zero-extended.
    assign pack_clr_d = rdy_in && (state_q == IDLE);
    assign pack_en_d  = rdy_in && ((state_q == LS_RD) || ((state_q == IF_RD) && !_clear));

    mem_byte_packer u_packer (
        .clk_i  (clk_in),
        .rst_ni (rst_n_in),
        .clr_i  (pack_clr_d),
        .en_i   (pack_en_d),
        .cnt_i  (cnt_q),
        .byte_i (mem_din),
        .word_o (pack_word_d)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            mem_ready_q <= 1'b0;
            lsb_done_q  <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_a_q     <= 32'd0;
            mem_dout_q  <= 8'd0;
            inst_q      <= 16'd0;
            lsb_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            mem_ready_q <= 1'b0;
            lsb_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (_lsb_req && !lsb_done_q) begin
                        mem_a_q <= _lsb_addr;
                        cnt_q   <= 2'd0;
                        if (_lsb_we) begin
                            state_q    <= LS_WR;
                            mem_dout_q <= _lsb_wdata[7:0];
                            mem_wr_q   <= !wr_stall_d;
                        end else begin
                            state_q <= LS_RD;
                        end
                    end else if (!_clear) begin
                        state_q <= IF_RD;
                        mem_a_q <= _ICache_addr;
                        cnt_q   <= 2'd0;
                    end
                end
                IF_RD: begin
                    if (_clear) begin
                        state_q <= IDLE;
                        cnt_q   <= 2'd0;
                    end else if (cnt_q == 2'd0) begin
                        mem_a_q <= mem_a_q + 32'd1;
                        cnt_q   <= 2'd1;
                    end else begin
                        inst_q      <= pack_word_d[15:0];
                        mem_ready_q <= 1'b1;
                        state_q     <= IDLE;
                        cnt_q       <= 2'd0;
                    end
                end
                LS_RD: begin
                    if (cnt_q == last_d) begin
                        lsb_rdata_q <= pack_word_d;
                        lsb_done_q  <= 1'b1;
                        state_q     <= IDLE;
                        cnt_q       <= 2'd0;
                    end else begin
                        mem_a_q <= mem_a_q + 32'd1;
                        cnt_q   <= cnt_inc_d;
                    end
                end
                LS_WR: begin
                    // mem_wr_q low here means the current byte is still held back by the UART.
                    if (mem_wr_q) begin
                        if (cnt_q == last_d) begin
                            lsb_done_q <= 1'b1;
                            mem_wr_q   <= 1'b0;
                            state_q    <= IDLE;
                            cnt_q      <= 2'd0;
                        end else begin
                            cnt_q      <= cnt_inc_d;
                            mem_a_q    <= mem_a_q + 32'd1;
                            mem_dout_q <= wbyte_d;
                            mem_wr_q   <= !wr_stall_d;
                        end
                    end else if (!wr_stall_d) begin
                        mem_wr_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign _mem_ready   = mem_ready_q;
    assign _mem_inst_in = inst_q;
    assign _lsb_done    = lsb_done_q;
    assign _lsb_rdata   = lsb_rdata_q;
    assign mem_a        = mem_a_q;
    assign mem_dout     = mem_dout_q;
    assign mem_wr       = mem_wr_q && rdy_in;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed fetch/load/store vectors queue their expected
// responses and RAM writes, and a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        _clear;
    logic [31:0] _ICache_addr;
    logic        _mem_ready;
    logic [15:0] _mem_inst_in;
    logic        _lsb_req;
    logic        _lsb_we;
    logic [31:0] _lsb_addr;
    logic [31:0] _lsb_wdata;
    logic [1:0]  _lsb_size;
    logic        _lsb_done;
    logic [31:0] _lsb_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } resp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    resp_t respQ[$];
    wr_t   wrQ[$];
    resp_t respExp;
    wr_t   wrExp;

    int cyc = 0;
    int checkCount = 0;
    int errorCount = 0;

    logic [7:0] ram [0:262143];

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .rdy_in         (rdy_in),
        ._clear         (_clear),
        ._ICache_addr   (_ICache_addr),
        ._mem_ready     (_mem_ready),
        ._mem_inst_in   (_mem_inst_in),
        ._lsb_req       (_lsb_req),
        ._lsb_we        (_lsb_we),
        ._lsb_addr      (_lsb_addr),
        ._lsb_wdata     (_lsb_wdata),
        ._lsb_size      (_lsb_size),
        ._lsb_done      (_lsb_done),
        ._lsb_rdata     (_lsb_rdata),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // RAM model: the byte for the address registered at one edge is sampled at the next.
    assign mem_din = ram[mem_a[17:0]];

    always @(posedge clk_in) begin
        if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every DUT response and RAM write must match the head of its queue.
    always @(negedge clk_in) begin
        if (_mem_ready) begin
            if (respQ.size() != 0 && respQ[0].kind == K_FETCH) begin
                respExp = respQ.pop_front();
                checkOutput("fetch_data", 32'(_mem_inst_in), respExp.data);
                checkOutput("fetch_cycle", 32'(cyc), 32'(respExp.cyc));
            end else begin
                checkOutput("mem_ready_unexpected", 32'(_mem_ready), 32'd0);
            end
        end
        if (_lsb_done) begin
            if (respQ.size() != 0 && respQ[0].kind != K_FETCH) begin
                respExp = respQ.pop_front();
                if (respExp.kind == K_LOAD) checkOutput("load_data", _lsb_rdata, respExp.data);
                checkOutput("lsb_done_cycle", 32'(cyc), 32'(respExp.cyc));
            end else begin
                checkOutput("lsb_done_unexpected", 32'(_lsb_done), 32'd0);
            end
        end
        if (mem_wr) begin
            if (wrQ.size() != 0) begin
                wrExp = wrQ.pop_front();
                checkOutput("write_addr", mem_a, wrExp.addr);
                checkOutput("write_data", 32'(mem_dout), 32'(wrExp.data));
                checkOutput("write_cycle", 32'(cyc), 32'(wrExp.cyc));
            end else begin
                checkOutput("mem_wr_unexpected", 32'(mem_wr), 32'd0);
            end
        end
    end

    // One LSU transaction, started at a negedge; the request is held until done.
    task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] size, input int stall, input logic [31:0] expRdata);
        int c;
        int n;
        int waited;
        resp_t r;
        wr_t w;
        c = cyc;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        _lsb_req = 1'b1;
        _lsb_we = we;
        _lsb_addr = addr;
        _lsb_wdata = wdata;
        _lsb_size = size;
        io_buffer_full = (stall != 0);
        if (we) begin
            for (int i = 0; i < n; i++) begin
                w.addr = addr + 32'(i);
                w.data = wdata[8*i +: 8];
                w.cyc = c + 1 + stall + i;
                wrQ.push_back(w);
            end
            r.kind = K_STORE;
            r.data = 32'd0;
            r.cyc = c + n + 1 + stall;
        end else begin
            r.kind = K_LOAD;
            r.data = expRdata;
            r.cyc = c + n + 1;
        end
        respQ.push_back(r);
        waited = 0;
        do begin
            @(negedge clk_in);
            waited++;
            if (waited == stall) io_buffer_full = 1'b0;
        end while (!_lsb_done && waited < 40);
        if (!_lsb_done) checkOutput("lsb_done_timeout", 32'(_lsb_done), 32'd1);
        _lsb_req = 1'b0;
        io_buffer_full = 1'b0;
    endtask

    // Opens a fetch window of exactly one fetch: _clear is low for the three fetch edges.
    task automatic fetchWindow(input logic [31:0] addr, input logic [15:0] expInst);
        resp_t r;
        r.kind = K_FETCH;
        r.data = 32'(expInst);
        r.cyc = cyc + 3;
        respQ.push_back(r);
        _ICache_addr = addr;
        _clear = 1'b0;
        repeat (3) @(negedge clk_in);
        _clear = 1'b1;
    endtask

    initial begin
        resp_t r;
        for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
        ram[18'h00100] = 8'h13; ram[18'h00101] = 8'h86;
        ram[18'h00200] = 8'h11; ram[18'h00201] = 8'h22;
        ram[18'h00202] = 8'h33; ram[18'h00203] = 8'h44;
        ram[18'h00210] = 8'h5A; ram[18'h00211] = 8'hA5;
        ram[18'h00400] = 8'hAA; ram[18'h00401] = 8'hBB;
        ram[18'h00500] = 8'h34; ram[18'h00501] = 8'h12;
        ram[18'h00600] = 8'h78; ram[18'h00601] = 8'h56;

        rst_n_in = 1'b0;
        rdy_in = 1'b1;
        _clear = 1'b1;
        _ICache_addr = 32'h0;
        _lsb_req = 1'b0;
        _lsb_we = 1'b0;
        _lsb_addr = 32'h0;
        _lsb_wdata = 32'h0;
        _lsb_size = 2'd0;
        io_buffer_full = 1'b0;

        repeat (2) @(negedge clk_in);
        checkOutput("reset_mem_a", mem_a, 32'd0);
        checkOutput("reset_mem_wr", 32'(mem_wr), 32'd0);
        checkOutput("reset_mem_ready", 32'(_mem_ready), 32'd0);
        checkOutput("reset_lsb_done", 32'(_lsb_done), 32'd0);
        rst_n_in = 1'b1;
        repeat (2) @(negedge clk_in);

        fetchWindow(32'h100, 16'h8613);
        @(negedge clk_in);

        // LSU request with fetching enabled: the load must win and no fetch may slip in.
        _clear = 1'b0;
        _ICache_addr = 32'h100;
        applyStimulus(1'b0, 32'h200, 32'h0, 2'd2, 0, 32'h4433_2211);
        _clear = 1'b1;
        @(negedge clk_in);

        applyStimulus(1'b0, 32'h203, 32'h0, 2'd0, 0, 32'h0000_0044);
        @(negedge clk_in);
        applyStimulus(1'b0, 32'h201, 32'h0, 2'd1, 0, 32'h0000_3322);
        @(negedge clk_in);
        applyStimulus(1'b1, 32'h300, 32'h0000_BEEF, 2'd1, 0, 32'h0);
        @(negedge clk_in);
        applyStimulus(1'b1, 32'h0003_0000, 32'h0000_005A, 2'd0, 4, 32'h0);
        @(negedge clk_in);
        applyStimulus(1'b1, 32'hFFFF_FFFE, 32'hCAFE_F00D, 2'd2, 0, 32'h0);
        @(negedge clk_in);
        applyStimulus(1'b0, 32'hFFFF_FFFE, 32'h0, 2'd2, 0, 32'hCAFE_F00D);
        @(negedge clk_in);

        // Flush one edge into a fetch of 0x400; the next fetch must come from 0x500.
        _ICache_addr = 32'h400;
        _clear = 1'b0;
        @(negedge clk_in);
        _clear = 1'b1;
        _ICache_addr = 32'h500;
        @(negedge clk_in);
        r.kind = K_FETCH;
        r.data = 32'h1234;
        r.cyc = cyc + 3;
        respQ.push_back(r);
        _clear = 1'b0;
        repeat (3) @(negedge clk_in);
        _clear = 1'b1;
        @(negedge clk_in);

        // Reset in the middle of a word load: outputs clear at once and no done follows.
        _lsb_req = 1'b1;
        _lsb_we = 1'b0;
        _lsb_addr = 32'h210;
        _lsb_size = 2'd2;
        repeat (2) @(negedge clk_in);
        checkOutput("midload_mem_a", mem_a, 32'h211);
        #2 rst_n_in = 1'b0;
        #1;
        checkOutput("async_reset_mem_a", mem_a, 32'd0);
        checkOutput("async_reset_rdata", _lsb_rdata, 32'd0);
        checkOutput("async_reset_inst", 32'(_mem_inst_in), 32'd0);
        checkOutput("async_reset_dout", 32'(mem_dout), 32'd0);
        checkOutput("async_reset_wr", 32'(mem_wr), 32'd0);
        _lsb_req = 1'b0;
        repeat (3) @(negedge clk_in);

        // Release reset with rdy_in low: nothing may move until rdy_in rises.
        rdy_in = 1'b0;
        _clear = 1'b0;
        _ICache_addr = 32'h600;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        checkOutput("frozen_mem_a", mem_a, 32'd0);
        @(negedge clk_in);
        rdy_in = 1'b1;
        fetchWindow(32'h600, 16'h5678);

        repeat (8) @(negedge clk_in);
        checkOutput("resp_queue_drained", 32'(respQ.size()), 32'd0);
        checkOutput("write_queue_drained", 32'(wrQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
